div_unit: RTL and testbench

Multi-cycle radix-2 restoring divider for the MIPS DIV/DIVU instructions, sitting in the execute stage directly downstream of the ALU-control decoder. When the decoder selects DIV_CONTROL or DIVU_CONTROL, the execute stage raises `start_i` with the operands. This block stalls the pipeline while it iterates, then returns `{remainder, quotient}` for the HI/LO write. It handles signed and unsigned operands, divide-by-zero, and annulment on a pipeline flush.

---
 rtl/div_unit_if.sv | 23 ++
 rtl/div_unit.sv | 146 ++++++++++++++
 tb/tb_div_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Execute-stage <-> divider handshake: operands/control in, stall/ready/result out.
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 signed_i;
  logic [WIDTH-1:0]     dividend_i;
  logic [WIDTH-1:0]     divisor_i;
  logic                 start_i;
  logic                 annul_i;
  logic                 busy_o;
  logic                 ready_o;
  logic [2*WIDTH-1:0]   result_o;

  modport master (
    output signed_i, dividend_i, divisor_i, start_i, annul_i,
    input  busy_o, ready_o, result_o
  );

  modport slave (
    input  signed_i, dividend_i, divisor_i, start_i, annul_i,
    output busy_o, ready_o, result_o
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU; returns {remainder, quotient}
// for the HI/LO write, one bit per cycle on unsigned magnitudes with a final sign fix-up.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  div_unit_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    DIVON   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_n;

  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [WIDTH-1:0]     r_div;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [2*WIDTH-1:0]   r_result;

  logic                 w_accept;
  logic                 w_busy;
  logic                 w_ready;
  logic                 w_last;
  logic                 w_div_zero;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_a_abs;
  logic [WIDTH-1:0]     w_b_abs;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH-1:0]     w_diff;
  logic [WIDTH-1:0]     w_q_fix;
  logic [WIDTH-1:0]     w_r_fix;

  // Operand conditioning at start
  assign w_div_zero = (bus.divisor_i == '0);
  assign w_a_abs    = (bus.signed_i && bus.dividend_i[WIDTH-1]) ? -bus.dividend_i
                                                                : bus.dividend_i;
  assign w_b_abs    = (bus.signed_i && bus.divisor_i[WIDTH-1])  ? -bus.divisor_i
                                                                : bus.divisor_i;

  // One restoring step: the partial remainder is always below the divisor, so the
  // stored remainder fits WIDTH bits; only the shifted trial value needs WIDTH+1.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_diff  = w_shift[WIDTH-1:0] - r_div;
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  assign w_q_fix = r_neg_q ? -r_quo : r_quo;
  assign w_r_fix = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_accept  = 1'b0;
    w_busy    = 1'b0;
    w_ready   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          w_accept  = 1'b1;
          w_busy    = 1'b1;
          w_state_n = w_div_zero ? DIVZERO : DIVON;
        end
      end
      DIVZERO: begin
        w_busy    = 1'b1;
        w_state_n = bus.annul_i ? IDLE : DONE;
      end
      DIVON: begin
        w_busy = 1'b1;
        if (bus.annul_i) begin
          w_state_n = IDLE;
        end else if (w_last) begin
          w_state_n = DONE;
        end
      end
      DONE: begin
        w_ready   = !bus.annul_i;
        w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_cnt <= '0;
        r_rem <= '0;
        r_div <= w_b_abs;
        if (w_div_zero) begin
          r_quo   <= '0;
          r_neg_q <= 1'b0;
          r_neg_r <= 1'b0;
        end else begin
          r_quo   <= w_a_abs;
          r_neg_q <= bus.signed_i && (bus.dividend_i[WIDTH-1] ^ bus.divisor_i[WIDTH-1]);
          r_neg_r <= bus.signed_i && bus.dividend_i[WIDTH-1];
        end
      end else if (r_state == DIVON && !bus.annul_i) begin
        r_cnt <= r_cnt + CW'(1);
        r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], w_ge};
      end
      if (w_ready) begin
        r_result <= {w_r_fix, w_q_fix};
      end
    end
  end

  // The fixed-up value is driven straight through during the ready cycle and held after.
  assign bus.busy_o   = w_busy;
  assign bus.ready_o  = w_ready;
  assign bus.result_o = w_ready ? {w_r_fix, w_q_fix} : r_result;

  a_cnt_range: assert property (@(posedge clk) disable iff (rst)
    (r_state == DIVON) |-> (r_cnt < CW'(WIDTH)));
  a_ready_not_busy: assert property (@(posedge clk) disable iff (rst)
    bus.ready_o |-> !bus.busy_o);

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus hand-built annul/reset/start-while-busy sequences.
module tb_div_unit;

  logic clk;
  logic rst;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         sgn;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [63:0]  exp;
    int           lat;
  } vec_t;

  vec_t vecs[9];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input string nm, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat);
    bus.signed_i   = sgn;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.start_i    = 1'b1;
    bus.annul_i    = 1'b0;
    for (int c = 0; c <= lat; c++) begin
      #2;
      chk({nm, " busy"},  64'(bus.busy_o),  64'(c < lat));
      chk({nm, " ready"}, 64'(bus.ready_o), 64'(c == lat));
      if (c == lat) chk({nm, " result"}, bus.result_o, exp);
      tick();
      bus.start_i = 1'b0;
    end
    #2;
    chk({nm, " ready after"}, 64'(bus.ready_o), 64'd0);
    chk({nm, " result held"}, bus.result_o, exp);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [63:0] prev;
    logic [63:0] got;
    int          n_rdy;

    vecs[0] = '{"divu 100/7",        1'b0, 32'd100,        32'd7,        {32'd2,        32'd14},        33};
    vecs[1] = '{"div -7/2",          1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD},  33};
    vecs[2] = '{"div 7/-2",          1'b1, 32'd7,          32'hFFFFFFFE, {32'd1,        32'hFFFFFFFD},  33};
    vecs[3] = '{"divu fff9/2",       1'b0, 32'hFFFFFFF9,   32'd2,        {32'd1,        32'h7FFFFFFC},  33};
    vecs[4] = '{"div 1234/0",        1'b1, 32'h00001234,   32'd0,        64'd0,                         2};
    vecs[5] = '{"div ovf",           1'b1, 32'h80000000,   32'hFFFFFFFF, {32'd0,        32'h80000000},  33};
    vecs[6] = '{"divu max/1",        1'b0, 32'hFFFFFFFF,   32'd1,        {32'd0,        32'hFFFFFFFF},  33};
    vecs[7] = '{"divu 7/9",          1'b0, 32'd7,          32'd9,        {32'd7,        32'd0},         33};
    vecs[8] = '{"div -100/-7",       1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14},        33};

    rst            = 1'b1;
    bus.signed_i   = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    bus.start_i    = 1'b0;
    bus.annul_i    = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #2;
    chk("reset busy",   64'(bus.busy_o),  64'd0);
    chk("reset ready",  64'(bus.ready_o), 64'd0);
    chk("reset result", bus.result_o,     64'd0);
    tick();

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end
    prev = vecs[8].exp;

    // Annul at cycle 10 of DIVU 100/7, new DIVU 9/3 issued at cycle 12
    bus.signed_i   = 1'b0;
    bus.dividend_i = 32'd100;
    bus.divisor_i  = 32'd7;
    bus.start_i    = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) bus.annul_i = 1'b1;
      #2;
      chk("annul ready", 64'(bus.ready_o), 64'd0);
      tick();
      bus.start_i = 1'b0;
    end
    bus.annul_i = 1'b0;
    #2;
    chk("annul busy",   64'(bus.busy_o),  64'd0);
    chk("annul ready2", 64'(bus.ready_o), 64'd0);
    chk("annul result", bus.result_o,     prev);
    tick();
    run_vec("divu 9/3 after annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

    // Start together with annul in IDLE is refused
    bus.dividend_i = 32'd100;
    bus.divisor_i  = 32'd7;
    bus.start_i    = 1'b1;
    bus.annul_i    = 1'b1;
    #2;
    chk("start+annul busy", 64'(bus.busy_o), 64'd0);
    tick();
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    #2;
    chk("start+annul busy next",  64'(bus.busy_o),  64'd0);
    chk("start+annul ready next", 64'(bus.ready_o), 64'd0);
    tick();

    // Start pulsed during DIVON is ignored: exactly one ready with 100/7's result
    n_rdy          = 0;
    got            = '0;
    bus.dividend_i = 32'd100;
    bus.divisor_i  = 32'd7;
    bus.start_i    = 1'b1;
    for (int c = 0; c < 70; c++) begin
      #2;
      if (bus.ready_o) begin
        n_rdy++;
        got = bus.result_o;
      end
      tick();
      bus.start_i = (c + 1 == 5);
      if (c + 1 == 5) begin
        bus.dividend_i = 32'd9;
        bus.divisor_i  = 32'd3;
      end
    end
    chk("busy-start ready count",  64'(n_rdy), 64'd1);
    chk("busy-start result",       got,        {32'd2, 32'd14});

    // Reset at cycle 20 of a divide
    bus.dividend_i = 32'd100;
    bus.divisor_i  = 32'd7;
    bus.start_i    = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      bus.start_i = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    chk("midreset busy",   64'(bus.busy_o),  64'd0);
    chk("midreset ready",  64'(bus.ready_o), 64'd0);
    chk("midreset result", bus.result_o,     64'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
